host_bus_if: RTL and testbench

HOST_BUS_IF -- requirements
Module: host_bus_if

---
 rtl/host_bus_pkg.sv | 21 ++
 rtl/host_bus_fifo.sv | 61 ++++++
 rtl/host_bus_if.sv | 213 +++++++++++++++++++++
 tb/tb_host_bus_if.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/host_bus_pkg.sv
// Shared types and constants for the host bus interface.
// No logic; types only.
// Entry layout matches the write-queue output ordering {a0, dat}.
package host_bus_pkg;

    localparam int ENTRY_W = 9;
    localparam int TMO_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRIVE = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic       a0;
        logic [7:0] dat;
    } wq_entry_t;

endpackage

// File: rtl/host_bus_fifo.sv
// Synchronous FIFO with extra-bit pointers for full/empty.
// Latency: a pushed entry is visible at dout/!empty the cycle after the push.
// Backpressure: a push while full is dropped unless a pop happens the same cycle.
module host_bus_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_x,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d                = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/host_bus_if.sv
// Asynchronous 8-bit host bus to core clock bridge: write queue plus read FSM.
// Latency: write entry visible 3 clk after wr_x rise is sampled; status read drives 3 clk after rd_x fall.
// Backpressure: core pops with wq_rdy; writes to a full queue are dropped and flagged on ovf.
module host_bus_if
    import host_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       cs_x,
    input  logic       a0,
    input  logic       rd_x,
    input  logic       wr_x,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       dat_oe,
    output logic       wq_vld,
    output logic       wq_a0,
    output logic [7:0] wq_dat,
    input  logic       wq_rdy,
    output logic       rd_req,
    input  logic       rd_vld,
    input  logic [7:0] rd_dat,
    input  logic [7:0] status,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    logic       cs_m_q, cs_s_q, a0_m_q, a0_s_q, rd_m_q, rd_s_q, wr_m_q, wr_s_q;
    logic [7:0] dat_m_q, dat_s_q;
    logic       cs_p_q, rd_p_q, wr_p_q;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            cs_m_q  <= 1'b1;
            cs_s_q  <= 1'b1;
            rd_m_q  <= 1'b1;
            rd_s_q  <= 1'b1;
            wr_m_q  <= 1'b1;
            wr_s_q  <= 1'b1;
            a0_m_q  <= 1'b0;
            a0_s_q  <= 1'b0;
            dat_m_q <= 8'h00;
            dat_s_q <= 8'h00;
            cs_p_q  <= 1'b1;
            rd_p_q  <= 1'b1;
            wr_p_q  <= 1'b1;
        end else begin
            cs_m_q  <= cs_x;
            cs_s_q  <= cs_m_q;
            rd_m_q  <= rd_x;
            rd_s_q  <= rd_m_q;
            wr_m_q  <= wr_x;
            wr_s_q  <= wr_m_q;
            a0_m_q  <= a0;
            a0_s_q  <= a0_m_q;
            dat_m_q <= dat_i;
            dat_s_q <= dat_m_q;
            cs_p_q  <= cs_s_q;
            rd_p_q  <= rd_s_q;
            wr_p_q  <= wr_s_q;
        end
    end

    // Edges are trusted only once the synchronisers and edge history hold real pin values,
    // so a strobe already low across reset release never looks like a fresh cycle.
    logic [2:0] boot_q, boot_d;
    logic       live;
    logic       wr_fall, wr_end, rd_fall;

    rd_state_t  state_q;
    wq_entry_t  cap_q, cap_d, push_dat_q, push_dat_d;
    logic       arm_q, arm_d, push_q, push_d, ovf_q, ovf_d;
    logic       rd_req_q, dat_oe_q;
    logic [7:0] dat_o_q;
    logic [TMO_W-1:0] tmo_q;

    wq_entry_t  head;
    logic       fifo_full, fifo_empty;

    assign live    = boot_q[2];
    assign wr_fall = live && wr_p_q && !wr_s_q && !cs_s_q;
    assign wr_end  = wr_s_q && !wr_p_q && !cs_p_q;
    assign rd_fall = live && rd_p_q && !rd_s_q && !cs_s_q && wr_s_q;

    always_comb begin
        boot_d = {boot_q[1:0], 1'b1};
        cap_d  = cap_q;
        if (!wr_s_q && !cs_s_q) begin
            cap_d = '{a0: a0_s_q, dat: dat_s_q};
        end
        arm_d = arm_q;
        if (wr_fall) begin
            arm_d = 1'b1;
        end
        if (wr_end || (cs_s_q && cs_p_q)) begin
            arm_d = 1'b0;
        end
        push_d     = wr_end && arm_q && (state_q == IDLE);
        push_dat_d = cap_q;
        ovf_d      = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (push_q && fifo_full && !wq_rdy) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            boot_q     <= 3'b000;
            cap_q      <= '0;
            arm_q      <= 1'b0;
            push_q     <= 1'b0;
            push_dat_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            boot_q     <= boot_d;
            cap_q      <= cap_d;
            arm_q      <= arm_d;
            push_q     <= push_d;
            push_dat_q <= push_dat_d;
            ovf_q      <= ovf_d;
        end
    end

    host_bus_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_x (rst_x),
        .push  (push_q),
        .din   (push_dat_q),
        .pop   (wq_rdy),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
            dat_oe_q <= 1'b0;
            dat_o_q  <= 8'h00;
            tmo_q    <= '0;
        end else begin
            rd_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_fall) begin
                        if (a0_s_q) begin
                            state_q  <= DRIVE;
                            dat_o_q  <= status;
                            dat_oe_q <= 1'b1;
                        end else begin
                            state_q  <= REQ;
                            rd_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (rd_s_q || cs_s_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT;
                        tmo_q   <= '0;
                    end
                end
                WAIT: begin
                    if (rd_s_q || cs_s_q) begin
                        state_q <= IDLE;
                    end else if (rd_vld) begin
                        state_q  <= DRIVE;
                        dat_o_q  <= rd_dat;
                        dat_oe_q <= 1'b1;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q  <= DRIVE;
                        dat_o_q  <= 8'hFF;
                        dat_oe_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (rd_s_q || cs_s_q) begin
                        state_q  <= IDLE;
                        dat_oe_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    dat_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign wq_vld = !fifo_empty;
    assign wq_a0  = head.a0;
    assign wq_dat = head.dat;
    assign rd_req = rd_req_q;
    assign dat_oe = dat_oe_q;
    assign dat_o  = dat_o_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_host_bus_if.sv
// Directed bench for host_bus_if: table of write/pop/flag steps plus hand-timed read and reset sequences.
module tb_host_bus_if;

    logic       clk = 1'b0;
    logic       rst_x, cs_x, a0, rd_x, wr_x, wq_rdy, rd_vld, ovf_clr;
    logic [7:0] dat_i, rd_dat, status;
    logic [7:0] dat_o, wq_dat;
    logic       dat_oe, wq_vld, wq_a0, rd_req, ovf;

    int n_run  = 0;
    int n_fail = 0;
    int rd_req_cnt = 0;

    always #5 clk = ~clk;

    host_bus_if #(.FIFO_DEPTH(4), .RD_TIMEOUT(15)) dut (
        .clk     (clk),
        .rst_x   (rst_x),
        .cs_x    (cs_x),
        .a0      (a0),
        .rd_x    (rd_x),
        .wr_x    (wr_x),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .dat_oe  (dat_oe),
        .wq_vld  (wq_vld),
        .wq_a0   (wq_a0),
        .wq_dat  (wq_dat),
        .wq_rdy  (wq_rdy),
        .rd_req  (rd_req),
        .rd_vld  (rd_vld),
        .rd_dat  (rd_dat),
        .status  (status),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always @(negedge clk) begin
        if (rd_req === 1'b1) rd_req_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam int OP_WR    = 0;
    localparam int OP_POP   = 1;
    localparam int OP_OVF   = 2;
    localparam int OP_CLR   = 3;
    localparam int OP_EMPTY = 4;

    typedef struct {
        int         op;
        logic       a0;
        logic [7:0] d;
        logic       exp_a0;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the negedge where wr_x is raised.
    task automatic wr_strobe(input logic a, input logic [7:0] d);
        cs_x  = 1'b0;
        a0    = a;
        dat_i = d;
        wr_x  = 1'b0;
        nclk(6);
        wr_x  = 1'b1;
        cs_x  = 1'b1;
    endtask

    task automatic pop_chk(input string name, input logic a, input logic [7:0] d);
        chk({name, "_vld"}, 32'(wq_vld), 32'd1);
        chk({name, "_a0"},  32'(wq_a0),  32'(a));
        chk({name, "_dat"}, 32'(wq_dat), 32'(d));
        wq_rdy = 1'b1;
        nclk(1);
        wq_rdy = 1'b0;
    endtask

    initial begin
        int base;
        int lat;

        vecs[0]  = '{OP_WR,    1'b0, 8'h01, 1'b0, 8'h00};
        vecs[1]  = '{OP_WR,    1'b0, 8'h02, 1'b0, 8'h00};
        vecs[2]  = '{OP_WR,    1'b0, 8'h03, 1'b0, 8'h00};
        vecs[3]  = '{OP_WR,    1'b0, 8'h04, 1'b0, 8'h00};
        vecs[4]  = '{OP_OVF,   1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{OP_WR,    1'b0, 8'h05, 1'b0, 8'h00};
        vecs[6]  = '{OP_OVF,   1'b0, 8'h00, 1'b0, 8'h01};
        vecs[7]  = '{OP_POP,   1'b0, 8'h00, 1'b0, 8'h01};
        vecs[8]  = '{OP_POP,   1'b0, 8'h00, 1'b0, 8'h02};
        vecs[9]  = '{OP_POP,   1'b0, 8'h00, 1'b0, 8'h03};
        vecs[10] = '{OP_POP,   1'b0, 8'h00, 1'b0, 8'h04};
        vecs[11] = '{OP_EMPTY, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[12] = '{OP_CLR,   1'b0, 8'h00, 1'b0, 8'h00};
        vecs[13] = '{OP_WR,    1'b1, 8'hAA, 1'b0, 8'h00};
        vecs[14] = '{OP_WR,    1'b0, 8'h55, 1'b0, 8'h00};
        vecs[15] = '{OP_POP,   1'b0, 8'h00, 1'b1, 8'hAA};
        vecs[16] = '{OP_POP,   1'b0, 8'h00, 1'b0, 8'h55};
        vecs[17] = '{OP_EMPTY, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[18] = '{OP_OVF,   1'b0, 8'h00, 1'b0, 8'h00};

        rst_x = 1'b0; cs_x = 1'b1; a0 = 1'b0; rd_x = 1'b1; wr_x = 1'b1;
        dat_i = 8'h00; wq_rdy = 1'b0; rd_vld = 1'b0; rd_dat = 8'h00;
        status = 8'h00; ovf_clr = 1'b0;
        nclk(3);
        chk("rst_wq_vld", 32'(wq_vld), 32'd0);
        chk("rst_wq_dat", 32'(wq_dat), 32'd0);
        chk("rst_dat_oe", 32'(dat_oe), 32'd0);
        chk("rst_dat_o",  32'(dat_o),  32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_ovf",    32'(ovf),    32'd0);
        rst_x = 1'b1;
        nclk(5);

        // Command write: entry appears exactly 3 edges after wr_x high is first sampled.
        wr_strobe(1'b1, 8'h40);
        nclk(3);
        chk("cmd_vld_early", 32'(wq_vld), 32'd0);
        nclk(1);
        pop_chk("cmd", 1'b1, 8'h40);
        chk("cmd_empty", 32'(wq_vld), 32'd0);

        for (int i = 0; i < 19; i++) begin
            case (vecs[i].op)
                OP_WR: begin
                    wr_strobe(vecs[i].a0, vecs[i].d);
                    nclk(5);
                end
                OP_POP: pop_chk($sformatf("vec%0d", i), vecs[i].exp_a0, vecs[i].exp_d);
                OP_OVF: chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_d[0]));
                OP_CLR: begin
                    ovf_clr = 1'b1;
                    nclk(1);
                    ovf_clr = 1'b0;
                    chk($sformatf("vec%0d_clr", i), 32'(ovf), 32'd0);
                end
                default: chk($sformatf("vec%0d_empty", i), 32'(wq_vld), 32'd0);
            endcase
        end

        // Full FIFO with push and pop landing on the same edge.
        wr_strobe(1'b0, 8'h11); nclk(5);
        wr_strobe(1'b0, 8'h22); nclk(5);
        wr_strobe(1'b0, 8'h33); nclk(5);
        wr_strobe(1'b0, 8'h44); nclk(5);
        wr_strobe(1'b0, 8'h66);
        nclk(3);
        chk("pp_head", 32'(wq_dat), 32'h11);
        wq_rdy = 1'b1;
        nclk(1);
        wq_rdy = 1'b0;
        chk("pp_ovf", 32'(ovf), 32'd0);
        pop_chk("pp1", 1'b0, 8'h22);
        pop_chk("pp2", 1'b0, 8'h33);
        pop_chk("pp3", 1'b0, 8'h44);
        pop_chk("pp4", 1'b0, 8'h66);
        chk("pp_empty", 32'(wq_vld), 32'd0);

        // Status read.
        base   = rd_req_cnt;
        status = 8'hA5;
        cs_x = 1'b0; a0 = 1'b1; rd_x = 1'b0;
        nclk(2);
        chk("st_oe_early", 32'(dat_oe), 32'd0);
        nclk(1);
        chk("st_oe", 32'(dat_oe), 32'd1);
        chk("st_dat", 32'(dat_o), 32'hA5);
        nclk(3);
        chk("st_oe_hold", 32'(dat_oe), 32'd1);
        rd_x = 1'b1; cs_x = 1'b1;
        nclk(3);
        chk("st_oe_off", 32'(dat_oe), 32'd0);
        chk("st_no_req", 32'(rd_req_cnt), 32'(base));

        // Data read answered two cycles after rd_req.
        nclk(2);
        base = rd_req_cnt;
        cs_x = 1'b0; a0 = 1'b0; rd_x = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            nclk(1);
            if (rd_req === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("rd_req_lat", 32'(lat), 32'd3);
        nclk(2);
        rd_vld = 1'b1; rd_dat = 8'h3C;
        nclk(1);
        rd_vld = 1'b0; rd_dat = 8'h00;
        chk("rd_oe", 32'(dat_oe), 32'd1);
        chk("rd_dat", 32'(dat_o), 32'h3C);
        chk("rd_req_once", 32'(rd_req_cnt), 32'(base + 1));
        rd_x = 1'b1; cs_x = 1'b1;
        nclk(3);
        chk("rd_oe_off", 32'(dat_oe), 32'd0);

        // Data read with no core answer times out to 8'hFF.
        nclk(2);
        base = rd_req_cnt;
        cs_x = 1'b0; a0 = 1'b0; rd_x = 1'b0;
        nclk(18);
        chk("tmo_oe_early", 32'(dat_oe), 32'd0);
        nclk(1);
        chk("tmo_oe", 32'(dat_oe), 32'd1);
        chk("tmo_dat", 32'(dat_o), 32'hFF);
        chk("tmo_req_once", 32'(rd_req_cnt), 32'(base + 1));
        rd_x = 1'b1; cs_x = 1'b1;
        nclk(4);

        // Reset in the middle of a write with the FIFO holding an entry.
        wr_strobe(1'b0, 8'h77);
        nclk(5);
        chk("pre_rst_vld", 32'(wq_vld), 32'd1);
        cs_x = 1'b0; a0 = 1'b0; dat_i = 8'h99; wr_x = 1'b0;
        nclk(3);
        rst_x = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(wq_vld), 32'd0);
        chk("mid_rst_dat", 32'(wq_dat), 32'd0);
        nclk(2);
        rst_x = 1'b1;
        nclk(6);
        wr_x = 1'b1; cs_x = 1'b1;
        nclk(8);
        chk("post_rst_vld", 32'(wq_vld), 32'd0);
        chk("post_rst_req", 32'(rd_req), 32'd0);
        wr_strobe(1'b0, 8'h5A);
        nclk(5);
        pop_chk("post_rst_wr", 1'b0, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
